// File: rtl/mgmt_spi_responder.sv
// rtl/mgmt_spi_responder.sv - SPI mode-0 responder bridging a host to an 8-bit housekeeping register bus
// Optional interrupt output enabled by defining MGMT_SPI_RESPONDER_IRQ_EN.
module mgmt_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  spi_sck,
  input  logic                  spi_csb,
  input  logic                  spi_sdi,
  output logic                  spi_sdo,
  output logic                  spi_sdo_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  output logic                  busy
`ifdef MGMT_SPI_RESPONDER_IRQ_EN
  ,
  output logic                  irq,
  input  logic                  irq_clear
`endif
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sck_sync, csb_sync, sdi_sync, fill;
  logic       sck_d, csb_d, csb_arm, sck_arm;
  logic       sck_s, csb_s, sdi_s;
  logic       sck_rise, sck_fall, csb_fall;
  logic       rise_ok, byte_done, cmd_valid;
  logic [7:0] in_byte;
  logic [6:0] shift_in;
  logic [7:0] shift_out;
  logic [2:0] bit_cnt;
  logic       cmd_wr, cmd_rd;
  logic       inc_pend, cap_pend;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign csb_s = csb_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  // A CSB fall only counts once a genuine high level has been seen after reset,
  // so a reset in the middle of a transfer cannot restart it.
  assign csb_fall = ~csb_s & csb_d & csb_arm;

  // Rising SCK counts only after SCK has been seen low inside the transaction.
  assign rise_ok   = sck_rise & sck_arm & ~csb_s &
                     ((state == CMD) || (state == ADDR) || (state == DATA));
  assign byte_done = rise_ok && (bit_cnt == 3'd7);
  assign in_byte   = {shift_in, sdi_s};
  assign cmd_valid = (in_byte[5:0] == 6'd0) && (in_byte[7:6] != 2'b00);

  assign busy       = ~csb_s;
  assign spi_sdo_oe = (state == DATA) && cmd_rd;
  assign spi_sdo    = spi_sdo_oe & shift_out[7];

  // Input synchronizers, edge-detect delay flops and post-reset CSB qualification.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sck_sync <= '0;
      csb_sync <= '1;
      sdi_sync <= '0;
      fill     <= '0;
      sck_d    <= 1'b0;
      csb_d    <= 1'b1;
      csb_arm  <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
      sck_d    <= sck_s;
      csb_d    <= csb_s;
      if (fill[SYNC_STAGES-1] && csb_s) csb_arm <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state logic; CSB high returns to IDLE from any active state.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (csb_fall)  state_n = CMD;
      CMD:     if (byte_done) state_n = cmd_valid ? ADDR : IGNORE;
      ADDR:    if (byte_done) state_n = DATA;
      default: ;
    endcase
    if ((state != IDLE) && csb_s) state_n = IDLE;
  end

  // Shift registers, command/address capture and register bus strobes.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sck_arm   <= 1'b0;
      shift_in  <= '0;
      shift_out <= '0;
      bit_cnt   <= '0;
      cmd_wr    <= 1'b0;
      cmd_rd    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      inc_pend  <= 1'b0;
      cap_pend  <= 1'b0;
    end else begin
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;
      inc_pend <= 1'b0;
      cap_pend <= reg_re;

      if (state == IDLE) sck_arm <= 1'b0;
      else if (!sck_s)   sck_arm <= 1'b1;

      if (csb_fall) begin
        bit_cnt   <= '0;
        cmd_wr    <= 1'b0;
        cmd_rd    <= 1'b0;
        shift_out <= '0;
      end

      if (rise_ok) begin
        shift_in <= in_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
      end

      if (byte_done) begin
        case (state)
          CMD: if (cmd_valid) begin
            cmd_wr <= in_byte[7];
            cmd_rd <= in_byte[6];
          end
          ADDR: begin
            reg_addr <= in_byte[ADDR_WIDTH-1:0];
            reg_re   <= cmd_rd;
          end
          DATA: begin
            if (cmd_wr) begin
              reg_wdata <= in_byte;
              reg_we    <= 1'b1;
            end
            inc_pend <= 1'b1;
          end
          default: ;
        endcase
      end

      if (inc_pend) begin
        reg_addr <= reg_addr + ADDR_WIDTH'(1);
        reg_re   <= cmd_rd && (state == DATA);
      end

      // Falls right after a byte boundary (bit_cnt==0) must not shift, otherwise
      // the freshly loaded MSB would be lost before the host samples it.
      if (cap_pend)
        shift_out <= reg_rdata;
      else if (sck_fall && (state == DATA) && (bit_cnt != 3'd0))
        shift_out <= {shift_out[6:0], 1'b0};
    end
  end

`ifdef MGMT_SPI_RESPONDER_IRQ_EN
  logic wr_seen;
  logic csb_rise;

  assign csb_rise = csb_s & ~csb_d;

  // Interrupt raised at the end of any transaction that completed a write byte.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_seen <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (csb_fall)                                      wr_seen <= 1'b0;
      else if (byte_done && (state == DATA) && cmd_wr)   wr_seen <= 1'b1;
      if (csb_rise && wr_seen) irq <= 1'b1;
      else if (irq_clear)      irq <= 1'b0;
    end
  end
`endif

endmodule
